// File: rtl/m3_pkg.sv
// Shared constants for the six-step PWM driver: FSM states, sector gate patterns, phase bit positions.
// Latency: n/a (package only).
// Backpressure: n/a.
package m3_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    localparam logic [2:0] SECTOR_IDLE = 3'd7;

    // Bit positions of each phase inside the 3-bit gate vectors (U is the MSB)
    localparam int PHASE_U = 2;
    localparam int PHASE_V = 1;
    localparam int PHASE_W = 0;

    localparam logic [2:0] GATE_U = 3'b001 << PHASE_U;
    localparam logic [2:0] GATE_V = 3'b001 << PHASE_V;
    localparam logic [2:0] GATE_W = 3'b001 << PHASE_W;

    // Sector patterns packed as {high-side, low-side}
    localparam logic [5:0] PAT_S0 = {GATE_U, GATE_V};
    localparam logic [5:0] PAT_S1 = {GATE_U, GATE_W};
    localparam logic [5:0] PAT_S2 = {GATE_V, GATE_W};
    localparam logic [5:0] PAT_S3 = {GATE_V, GATE_U};
    localparam logic [5:0] PAT_S4 = {GATE_W, GATE_U};
    localparam logic [5:0] PAT_S5 = {GATE_W, GATE_V};

    function automatic logic [5:0] sector_pat(input logic [2:0] sector);
        case (sector)
            3'd0:    sector_pat = PAT_S0;
            3'd1:    sector_pat = PAT_S1;
            3'd2:    sector_pat = PAT_S2;
            3'd3:    sector_pat = PAT_S3;
            3'd4:    sector_pat = PAT_S4;
            3'd5:    sector_pat = PAT_S5;
            default: sector_pat = 6'b000_000;
        endcase
    endfunction

endpackage

// File: rtl/m3_sixsteppwmdriver_if.sv
// Command inputs and gate outputs of the six-step driver grouped as one bundle.
// Latency: n/a (wiring only).
// Backpressure: none; inputs are sampled every cycle.
interface m3_sixsteppwmdriver_if;
    logic [3:0] stepI;
    logic [9:0] powerLevelI;
    logic       invRotateI;
    logic       forceStopI;
    logic [2:0] hiO;
    logic [2:0] loO;
    logic [2:0] sectorO;
    logic       drivingO;

    modport master (
        output stepI, powerLevelI, invRotateI, forceStopI,
        input  hiO, loO, sectorO, drivingO
    );

    modport slave (
        input  stepI, powerLevelI, invRotateI, forceStopI,
        output hiO, loO, sectorO, drivingO
    );
endinterface

// File: rtl/m3_pwmCarrier.sv
// PWM carrier: free-running period counter plus a duty register that only reloads at the wrap.
// Latency: pwm_on is the high-side enable for the cycle after the coming edge (matches the registered gates).
// Backpressure: none; power_level is sampled only on the wrap cycle.
module m3_pwmCarrier #(
    parameter int PWM_PERIOD = 1000
) (
    input  logic       clkI,
    input  logic       nRstI,
    input  logic [9:0] power_level,
    output logic       pwm_on
);
    localparam logic [9:0] PERIOD   = 10'(PWM_PERIOD);
    localparam logic [9:0] CNT_LAST = 10'(PWM_PERIOD - 1);

    logic [9:0] pwm_cnt;
    logic [9:0] duty_reg;
    logic [9:0] cnt_nxt;
    logic [9:0] duty_nxt;
    logic [9:0] duty_clamped;
    logic       wrap;

    // Next carrier count and duty; duty only moves at the wrap so a period is never split
    always_comb begin
        wrap         = (pwm_cnt == CNT_LAST);
        duty_clamped = (power_level > PERIOD) ? PERIOD : power_level;
        cnt_nxt      = wrap ? 10'd0 : pwm_cnt + 10'd1;
        duty_nxt     = wrap ? duty_clamped : duty_reg;
        // Evaluated on next-cycle values because the top registers the gates on the same edge
        pwm_on       = (cnt_nxt < duty_nxt);
    end

    // Carrier counter and duty register
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            pwm_cnt  <= 10'd0;
            duty_reg <= 10'd0;
        end else begin
            pwm_cnt  <= cnt_nxt;
            duty_reg <= duty_nxt;
        end
    end

endmodule

// File: rtl/m3_sixsteppwmdriver.sv
// Six-step bridge driver: step index -> sector, dead-time blanking on every sector change, PWM on the high side.
// Latency: gates registered, one cycle after inputs are sampled; DEAD_TIME all-off cycles before any new sector.
// Backpressure: none; forceStopI is honoured every cycle with top priority.
module m3_sixsteppwmdriver
    import m3_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int DEAD_TIME  = 4
) (
    input logic                  clkI,
    input logic                  nRstI,
    m3_sixsteppwmdriver_if.slave bus
);
    localparam logic [3:0] BLANK_LOAD = 4'(DEAD_TIME - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] blank_cnt;
    logic [3:0] blank_nxt;
    logic [2:0] cur_sector;
    logic [2:0] sector_nxt;
    logic [2:0] raw_sector;
    logic [2:0] target;
    logic       target_vld;
    logic       drive_nxt;
    logic       pwm_on;
    logic [5:0] pat;

    m3_pwmCarrier #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_carrier (
        .clkI        (clkI),
        .nRstI       (nRstI),
        .power_level (bus.powerLevelI),
        .pwm_on      (pwm_on)
    );

    // Map the 12-step index onto one of six sectors; reverse rotation mirrors the order
    always_comb begin
        target_vld = (bus.stepI <= 4'd11);
        raw_sector = bus.stepI[3:1];
        if (!target_vld) begin
            target = SECTOR_IDLE;
        end else if (bus.invRotateI) begin
            target = 3'd5 - raw_sector;
        end else begin
            target = raw_sector;
        end
    end

    // Next-state logic; any sector change, including jumps, is routed through BLANK
    always_comb begin
        state_nxt  = state;
        blank_nxt  = blank_cnt;
        sector_nxt = cur_sector;
        if (bus.forceStopI) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    if (target_vld) begin
                        state_nxt = ST_BLANK;
                        blank_nxt = BLANK_LOAD;
                    end
                end
                ST_BLANK: begin
                    // The target seen on the final blank cycle wins; earlier changes do not restart the blank
                    if (blank_cnt == 4'd0) begin
                        if (target_vld) begin
                            state_nxt  = ST_DRIVE;
                            sector_nxt = target;
                        end else begin
                            state_nxt = ST_OFF;
                        end
                    end else begin
                        blank_nxt = blank_cnt - 4'd1;
                    end
                end
                ST_DRIVE: begin
                    if (!target_vld) begin
                        state_nxt = ST_OFF;
                    end else if (target != cur_sector) begin
                        state_nxt = ST_BLANK;
                        blank_nxt = BLANK_LOAD;
                    end
                end
                default: state_nxt = ST_OFF;
            endcase
        end
        drive_nxt = (state_nxt == ST_DRIVE);
        pat       = sector_pat(sector_nxt);
    end

    // FSM state and registered gate outputs; the hi/lo pair comes from disjoint patterns so a phase never shoots through
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state        <= ST_OFF;
            blank_cnt    <= 4'd0;
            cur_sector   <= SECTOR_IDLE;
            bus.hiO      <= 3'b000;
            bus.loO      <= 3'b000;
            bus.sectorO  <= SECTOR_IDLE;
            bus.drivingO <= 1'b0;
        end else begin
            state        <= state_nxt;
            blank_cnt    <= blank_nxt;
            cur_sector   <= sector_nxt;
            bus.hiO      <= drive_nxt ? (pat[5:3] & {3{pwm_on}}) : 3'b000;
            bus.loO      <= drive_nxt ? pat[2:0] : 3'b000;
            bus.sectorO  <= drive_nxt ? sector_nxt : SECTOR_IDLE;
            bus.drivingO <= drive_nxt;
        end
    end

endmodule

// File: tb/tb_m3_sixsteppwmdriver.sv
// Directed bench for the six-step PWM driver: reset, rotation, duty, stop, async reset, random shoot-through watch.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_m3_sixsteppwmdriver;

    logic clkI  = 1'b0;
    logic nRstI = 1'b0;
    always #5 clkI = ~clkI;

    m3_sixsteppwmdriver_if bus();

    m3_sixsteppwmdriver #(
        .PWM_PERIOD (1000),
        .DEAD_TIME  (4)
    ) dut (
        .clkI  (clkI),
        .nRstI (nRstI),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int mcnt;

    // Expected gate patterns per sector, U = bit 2, V = bit 1, W = bit 0
    logic [2:0] exp_hi [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    logic [2:0] exp_lo [6] = '{3'b010, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};

    // Reference carrier position, used only to align duty measurements to carrier periods
    always @(posedge clkI or negedge nRstI) begin
        if (!nRstI) mcnt <= 0;
        else        mcnt <= (mcnt == 999) ? 0 : mcnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clkI);
        #1;
    endtask

    // Shoot-through and sector/driving consistency on every cycle out of reset
    always @(posedge clkI) begin
        #1;
        if (nRstI) begin
            check("shoot_through", 32'(bus.hiO & bus.loO), 0);
            check("sector_consistent",
                  32'(bus.drivingO ? (bus.sectorO <= 3'd5) : (bus.sectorO == 3'd7)), 1);
        end
    end

    // Apply one step for 100 cycles: expect `blank` all-off cycles, then a steady pattern for `sec`
    task automatic run_step(input logic [3:0] step, input logic [2:0] sec, input int blank);
        int bad_blank  = 0;
        int bad_steady = 0;
        bus.stepI = step;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (i < blank) begin
                if (bus.hiO !== 3'b000 || bus.loO !== 3'b000 || bus.drivingO !== 1'b0) bad_blank++;
            end else begin
                if (i == blank) begin
                    check($sformatf("sector_step%0d", step), 32'(bus.sectorO), 32'(sec));
                    check($sformatf("hi_step%0d", step), 32'(bus.hiO), 32'(exp_hi[sec]));
                    check($sformatf("lo_step%0d", step), 32'(bus.loO), 32'(exp_lo[sec]));
                end
                if (bus.loO !== exp_lo[sec] || bus.hiO !== exp_hi[sec] || bus.sectorO !== sec) bad_steady++;
            end
        end
        if (blank > 0) check($sformatf("blank_step%0d", step), 32'(bad_blank), 0);
        check($sformatf("steady_step%0d", step), 32'(bad_steady), 0);
    endtask

    task automatic wait_wrap();
        int found = 0;
        for (int i = 0; i < 1100 && found == 0; i++) begin
            cyc();
            if (mcnt == 0) found = 1;
        end
        check("wrap_found", 32'(found), 1);
    endtask

    // Count high-side-on cycles over one carrier period starting at carrier position 0
    task automatic count_period(output int n, input int change_at, input logic [9:0] new_power,
                                input logic [2:0] sec);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == change_at) bus.powerLevelI = new_power;
            if (bus.hiO === exp_hi[sec]) n++;
            cyc();
        end
    endtask

    initial begin
        int n;
        int bad;

        bus.stepI       = 4'd15;
        bus.powerLevelI = 10'd1000;
        bus.invRotateI  = 1'b0;
        bus.forceStopI  = 1'b0;

        // Reset state
        #12;
        check("rst_hi", 32'(bus.hiO), 0);
        check("rst_lo", 32'(bus.loO), 0);
        check("rst_sector", 32'(bus.sectorO), 7);
        check("rst_driving", 32'(bus.drivingO), 0);
        #10 nRstI = 1'b1;

        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (bus.hiO !== 3'b000 || bus.loO !== 3'b000 || bus.sectorO !== 3'd7 || bus.drivingO !== 1'b0) bad++;
        end
        check("idle_hold", 32'(bad), 0);

        // Forward rotation at full power
        for (int s = 0; s < 12; s++) begin
            run_step(4'(s), 3'(s / 2), (s % 2 == 0) ? 4 : 0);
        end

        // Reverse rotation: step 0 maps to sector 5 (same as current, no blank), step 2 to sector 4
        bus.invRotateI = 1'b1;
        run_step(4'd0, 3'd5, 0);
        run_step(4'd2, 3'd4, 4);

        // Duty: sector 2, 250 then 600 from the following wrap, then clamp, then zero
        bus.invRotateI  = 1'b0;
        bus.stepI       = 4'd4;
        bus.powerLevelI = 10'd250;
        repeat (10) cyc();
        wait_wrap();
        count_period(n, 500, 10'd600, 3'd2);
        check("duty_250", 32'(n), 250);
        count_period(n, -1, 10'd0, 3'd2);
        check("duty_600", 32'(n), 600);
        bus.powerLevelI = 10'd1023;
        wait_wrap();
        count_period(n, -1, 10'd0, 3'd2);
        check("duty_clamp", 32'(n), 1000);
        bus.powerLevelI = 10'd0;
        wait_wrap();
        count_period(n, -1, 10'd0, 3'd2);
        check("duty_zero", 32'(n), 0);
        check("duty_zero_lo", 32'(bus.loO), 32'(exp_lo[2]));

        // Force stop pulse during DRIVE
        bus.powerLevelI = 10'd1000;
        wait_wrap();
        cyc();
        check("pre_stop_hi", 32'(bus.hiO), 32'(exp_hi[2]));
        bus.forceStopI = 1'b1;
        cyc();
        bus.forceStopI = 1'b0;
        check("stop_gates", 32'({bus.hiO, bus.loO}), 0);
        check("stop_driving", 32'(bus.drivingO), 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.hiO !== 3'b000 || bus.loO !== 3'b000 || bus.drivingO !== 1'b0) bad++;
        end
        check("stop_blank", 32'(bad), 0);
        cyc();
        check("resume_driving", 32'(bus.drivingO), 1);
        check("resume_hi", 32'(bus.hiO), 32'(exp_hi[2]));
        check("resume_lo", 32'(bus.loO), 32'(exp_lo[2]));

        // Async reset mid-BLANK, then re-entry from OFF with duty back at its reset value
        bus.stepI = 4'd6;
        cyc();
        cyc();
        #2 nRstI = 1'b0;
        #1;
        check("arst_blank_gates", 32'({bus.hiO, bus.loO}), 0);
        check("arst_blank_sector", 32'(bus.sectorO), 7);
        @(negedge clkI);
        nRstI = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.hiO !== 3'b000 || bus.loO !== 3'b000 || bus.drivingO !== 1'b0) bad++;
        end
        check("arst_reblank", 32'(bad), 0);
        cyc();
        check("arst_redrive_sector", 32'(bus.sectorO), 3);
        check("arst_redrive_lo", 32'(bus.loO), 32'(exp_lo[3]));
        check("arst_duty_reset_hi", 32'(bus.hiO), 0);

        // Async reset mid-DRIVE clears the gates without waiting for an edge
        @(negedge clkI);
        nRstI = 1'b0;
        #1;
        check("arst_drive_gates", 32'({bus.hiO, bus.loO}), 0);
        check("arst_drive_driving", 32'(bus.drivingO), 0);
        @(negedge clkI);
        nRstI = 1'b1;

        // Random stepping, rotation toggles and stop pulses under the per-cycle watchers
        bus.powerLevelI = 10'd500;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 6) == 0) bus.stepI = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) bus.invRotateI = ~bus.invRotateI;
            bus.forceStopI = ($urandom_range(0, 99) == 0);
            cyc();
        end
        bus.forceStopI = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
